// File: rtl/bomb_game_pkg.sv
// Shared types and helpers for the bomb game blocks: reveal FSM states and the
// active-high 7-segment decoder.
package bomb_game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } reveal_state_t;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] CAT_OFF   = 8'hFF;
    localparam logic [7:0] CAT_D0    = 8'hFE;
    localparam logic [7:0] CAT_D1    = 8'hFD;

    // Segment order {dp,g,f,e,d,c,b,a}; dp is never lit.
    function automatic logic [7:0] seg7_of(input logic [3:0] digit);
        case (digit)
            4'd0:    return 8'h3F;
            4'd1:    return 8'h06;
            4'd2:    return 8'h5B;
            4'd3:    return 8'h4F;
            4'd4:    return 8'h66;
            4'd5:    return 8'h6D;
            4'd6:    return 8'h7D;
            4'd7:    return 8'h07;
            4'd8:    return 8'h7F;
            4'd9:    return 8'h6F;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/password_reveal_if.sv
// Control and display bundle between the game FSM / board I/O and password_reveal.
interface password_reveal_if #(
    parameter int PSW_W = 7
);
    logic             start;
    logic             abort;
    logic [PSW_W-1:0] psw;
    logic [PSW_W-1:0] LD;
    logic [7:0]       seg;
    logic [7:0]       cat;
    logic             busy;
    logic             end_of_show;

    modport master (
        output start, abort, psw,
        input  LD, seg, cat, busy, end_of_show
    );

    modport slave (
        input  start, abort, psw,
        output LD, seg, cat, busy, end_of_show
    );
endinterface

// File: rtl/password_reveal_seg7_scan.sv
// Two-digit scanned 7-seg driver for the reveal countdown: digit 0 = ones,
// digit 1 = tens (blanked when zero). seg/cat are registered.
module seg7_scan
    import bomb_game_pkg::*;
#(
    parameter int SCAN_DIV = 50,
    parameter int REM_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [REM_W-1:0] remaining,
    output logic [7:0]       seg,
    output logic [7:0]       cat
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [7:0]       seg_d, cat_d;
    logic [6:0]       rem7;
    logic [3:0]       ones, tens;

    assign rem7 = 7'(remaining);
    assign ones = 4'(rem7 % 7'd10);
    assign tens = 4'(rem7 / 7'd10);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = '0;
        sel_d = 1'b0;
        seg_d = SEG_BLANK;
        cat_d = CAT_OFF;
        if (enable && !load) begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_d = '0;
                sel_d = ~sel_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                sel_d = sel_q;
            end
        end
        // Registers carry the slot being entered, so the display lines up with LD.
        if (enable) begin
            if (!sel_d) begin
                seg_d = seg7_of(ones);
                cat_d = CAT_D0;
            end else if (tens != 4'd0) begin
                seg_d = seg7_of(tens);
                cat_d = CAT_D1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sel_q <= 1'b0;
            seg   <= SEG_BLANK;
            cat   <= CAT_OFF;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            seg   <= seg_d;
            cat   <= cat_d;
        end
    end

endmodule

// File: rtl/password_reveal.sv
// Timed password reveal: latches psw on start, shows it on LD with a seconds countdown.
// Optional build macro SHOW_BLINK_EN blinks LD during the final second.
module password_reveal
    import bomb_game_pkg::*;
#(
    parameter int PSW_W    = 7,
    parameter int SHOW_SEC = 5,
    parameter int TICK_DIV = 1000,
    parameter int SCAN_DIV = 50
) (
    input  logic              clk,
    input  logic              rst,
    password_reveal_if.slave  bus
);

    localparam int REM_W = $clog2(SHOW_SEC + 1);
    localparam int PRE_W = $clog2(TICK_DIV);

    reveal_state_t    state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [PSW_W-1:0] psw_q, psw_d;
    logic [PSW_W-1:0] ld_q, ld_d;
    logic             eos_q, eos_d;
    logic             busy_q;
    logic             tick;
    logic             load;

    assign tick = (state_q == SHOW) && (pre_q == PRE_W'(TICK_DIV - 1));
    assign load = bus.start && !bus.abort;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        rem_d   = rem_q;
        psw_d   = psw_q;
        eos_d   = eos_q;
        if (bus.abort) begin
            state_d = IDLE;
            pre_d   = '0;
            rem_d   = '0;
            psw_d   = '0;
            eos_d   = 1'b0;
        end else if (bus.start) begin
            // A start also wins over a coincident tick: the count reloads undecremented.
            state_d = SHOW;
            pre_d   = '0;
            rem_d   = REM_W'(SHOW_SEC);
            psw_d   = bus.psw;
            eos_d   = 1'b0;
        end else if (state_q == SHOW) begin
            if (tick) begin
                pre_d = '0;
                if (rem_q != '0) rem_d = rem_q - REM_W'(1);
                if (rem_q <= REM_W'(1)) begin
                    state_d = DONE;
                    eos_d   = 1'b1;
                end
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

`ifdef SHOW_BLINK_EN
    localparam logic [PRE_W-1:0] BLINK_Q = PRE_W'(TICK_DIV / 4);
    logic [PRE_W-1:0] blink_phase;
    assign blink_phase = pre_d / BLINK_Q;

    // Final second: alternate psw / dark every TICK_DIV/4 cycles, psw first.
    always_comb begin
        ld_d = '0;
        if (state_d == SHOW)
            ld_d = (rem_d == REM_W'(1) && blink_phase[0]) ? '0 : psw_d;
    end
`else
    always_comb begin
        ld_d = '0;
        if (state_d == SHOW) ld_d = psw_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            rem_q   <= '0;
            psw_q   <= '0;
            ld_q    <= '0;
            eos_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            psw_q   <= psw_d;
            ld_q    <= ld_d;
            eos_q   <= eos_d;
            busy_q  <= (state_d == SHOW);
        end
    end

    assign bus.LD          = ld_q;
    assign bus.busy        = busy_q;
    assign bus.end_of_show = eos_q;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV),
        .REM_W    (REM_W)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .enable    (state_d == SHOW),
        .load      (load),
        .remaining (rem_d),
        .seg       (bus.seg),
        .cat       (bus.cat)
    );

endmodule
